// File: rtl/adc_ram_wr.sv
// adc_ram_wr: captures one frame of DEPTH ADC samples into a RAM write port.
// The optional level trigger is enabled by defining ADC_RAM_WR_TRIG_EN.
// When it is undefined, arm starts capture directly.
module adc_ram_wr #(
  parameter int DEPTH = 2048,
  parameter int AW    = 13,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic [DW-1:0] trig_level,
  input  logic          arm,
  input  logic          ack,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TRIG, S_CAPTURE, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_cnt;
  logic          w_trig;
  logic          w_accept;
  logic          w_last;

`ifdef ADC_RAM_WR_TRIG_EN
  logic [DW-1:0] r_prev;
  logic          r_primed;

  // A crossing needs a real earlier sample, so the cleared prev_sample alone never fires the trigger.
  assign w_trig = r_state == S_WAIT_TRIG && adc_valid && r_primed &&
                  r_prev < trig_level && adc_data >= trig_level;

  // Track the previous valid sample; arming restarts crossing detection from scratch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
    end else if (r_state == S_IDLE && arm) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
    end else if (adc_valid) begin
      r_prev   <= adc_data;
      r_primed <= 1'b1;
    end
  end
`else
  logic w_unused_trig;
  assign w_unused_trig = ^trig_level;
  assign w_trig        = 1'b0;
`endif

  assign w_last   = r_cnt == AW'(DEPTH - 1);
  assign w_accept = (r_state == S_CAPTURE && adc_valid) || w_trig;
  assign busy     = r_state == S_WAIT_TRIG || r_state == S_CAPTURE;
  assign done     = r_state == S_DONE;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state: arm only counts in IDLE, ack only in DONE, so arm+ack in DONE just returns to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
`ifdef ADC_RAM_WR_TRIG_EN
      S_IDLE:      w_next = arm ? S_WAIT_TRIG : S_IDLE;
`else
      S_IDLE:      w_next = arm ? S_CAPTURE : S_IDLE;
`endif
      S_WAIT_TRIG: w_next = w_trig ? (w_last ? S_DONE : S_CAPTURE) : S_WAIT_TRIG;
      S_CAPTURE:   w_next = (w_accept && w_last) ? S_DONE : S_CAPTURE;
      S_DONE:      w_next = ack ? S_IDLE : S_DONE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Register each accepted sample into the write port one cycle later and advance the frame address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      r_cnt   <= '0;
    end else begin
      wr_en <= w_accept;
      if (w_accept) begin
        wr_addr <= r_cnt;
        wr_data <= adc_data;
      end
      r_cnt <= (r_state == S_IDLE) ? '0 : w_accept ? r_cnt + AW'(1) : r_cnt;
    end
  end

endmodule

// File: tb/tb_adc_ram_wr.sv
// tb_adc_ram_wr: directed self-checking bench for adc_ram_wr, in both trigger builds.
module tb_adc_ram_wr;
  localparam int DEPTH = 2048;
  localparam int AW    = 13;
  localparam int DW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          arm = 1'b0;
  logic          ack = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adc_ram_wr #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .trig_level(trig_level), .arm(arm), .ack(ack), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    arm = 1'b1;
    repeat (3) tick();
    arm = 1'b0;
    n_tests++;
    if ({wr_en, wr_addr, wr_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset: wr_en=%0b wr_addr=%0d wr_data=%0d busy=%0b done=%0b, expected all 0",
               wr_en, wr_addr, wr_data, busy, done);
    end
    rst_n = 1'b1;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack: busy=%0b done=%0b wr_en=%0b, expected 0 0 0", busy, done, wr_en);
    end
  endtask

  task automatic test_frame(input string name, input int period, input int base,
                            input int first, input int exp_vb, input int budget);
    int   j = 0;
    int   n_wr = 0;
    int   n_vb = 0;
    logic pv;
    logic fin = 1'b0;
    arm = 1'b1;
    adc_valid = 1'b0;
    tick();
    arm = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s arm: busy=%0b done=%0b, expected 1 0", name, busy, done);
    end
    for (int c = 0; c < budget && !fin; c++) begin
      adc_valid = (c % period) == 0;
      adc_data  = DW'((base + j) % 1024);
      pv = adc_valid;
      if (adc_valid) begin
        if (busy) n_vb++;
        j++;
      end
      tick();
      if (wr_en) begin
        n_tests++;
        if (!pv || wr_addr !== AW'(n_wr) || wr_data !== DW'((first + n_wr) % 1024)) begin
          n_fail++;
          $display("FAIL %s write %0d: wr_addr=%0d wr_data=%0d valid_before=%0b, expected addr %0d data %0d valid_before 1",
                   name, n_wr, wr_addr, wr_data, pv, n_wr, (first + n_wr) % 1024);
        end
        n_wr++;
      end
      fin = done;
    end
    adc_valid = 1'b0;
    n_tests++;
    if (n_wr != DEPTH || fin !== 1'b1) begin
      n_fail++;
      $display("FAIL %s count: writes=%0d done=%0b, expected %0d writes and done 1", name, n_wr, fin, DEPTH);
    end
    n_tests++;
    if (n_vb != exp_vb) begin
      n_fail++;
      $display("FAIL %s valids_busy: got %0d, expected %0d", name, n_vb, exp_vb);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_done: busy=%0b with done, expected 0", name, busy);
    end
    adc_valid = 1'b1;
    adc_data  = DW'(77);
    tick();
    adc_valid = 1'b0;
    n_tests++;
    if (wr_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post_done: wr_en=%0b done=%0b busy=%0b, expected 0 1 0", name, wr_en, done, busy);
    end
  endtask

  task automatic test_done_arm_ack();
    int bad = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL done_arm_ignored: done=%0b busy=%0b wr_en=%0b, expected 1 0 0", done, busy, wr_en);
    end
    arm = 1'b1;
    ack = 1'b1;
    tick();
    arm = 1'b0;
    ack = 1'b0;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_ack_idle: done=%0b busy=%0b, expected 0 0", done, busy);
    end
    adc_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      adc_data = DW'(500 + 20 * c);
      tick();
      if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) bad++;
    end
    adc_valid = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_after_ack: %0d cycles with activity, expected 0", bad);
    end
  endtask

  task automatic test_no_trig_const();
    int bad = 0;
    trig_level = DW'(512);
    adc_valid = 1'b1;
    adc_data = DW'(600);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 0; c < 300; c++) begin
      ack = (c % 7) == 0;
      tick();
      if (busy !== 1'b1 || wr_en !== 1'b0 || done !== 1'b0) bad++;
    end
    ack = 1'b0;
    adc_valid = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_trig_const: %0d bad cycles, expected busy=1 wr_en=0 throughout", bad);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL no_trig_reset: busy=%0b done=%0b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid(input int base);
    int n_wr = 0;
    int j = 0;
    int bad = 0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 0; c < 1000 && n_wr < 100; c++) begin
      adc_valid = 1'b1;
      adc_data = DW'((base + j) % 1024);
      j++;
      tick();
      if (wr_en) n_wr++;
    end
    n_tests++;
    if (n_wr != 100 || busy !== 1'b1 || wr_addr !== AW'(99)) begin
      n_fail++;
      $display("FAIL reset_mid_setup: writes=%0d busy=%0b wr_addr=%0d, expected 100 1 99", n_wr, busy, wr_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({wr_en, wr_addr, wr_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: wr_en=%0b wr_addr=%0d wr_data=%0d busy=%0b done=%0b, expected all 0",
               wr_en, wr_addr, wr_data, busy, done);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      adc_data = DW'((base + j + c) % 1024);
      ack = c[0];
      tick();
      if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    ack = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d cycles with activity before arm, expected 0", bad);
    end
    adc_valid = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_after_reset: busy=%0b, expected 1", busy);
    end
  endtask

  initial begin
    test_reset();
`ifdef ADC_RAM_WR_TRIG_EN
    test_no_trig_const();
    trig_level = DW'(512);
    test_frame("ramp_trig", 1, 100, 512, 2460, 3000);
    test_done_arm_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    test_frame("trig_1in4", 4, 0, 512, 2560, 10400);
    test_reset_mid(400);
`else
    test_frame("valid_1in4", 4, 5, 5, 2048, 8300);
    test_done_arm_ack();
    test_frame("every_cycle", 1, 1000, 1000, 2048, 2200);
    test_reset_mid(0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
